// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IC_FILL = 2'd1,
      DC_FILL = 2'd2,
      DC_WB   = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } requester_t;

   localparam int unsigned MEM_WORD_BYTES = 4;

   // Mask that clears the in-line byte offset for a line of the given word count.
   function automatic logic [31:0] line_mask(input int unsigned words);
      return ~(32'(words * MEM_WORD_BYTES) - 32'd1);
   endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat index counter for a memory burst; flags the final beat of a runtime-selected length.
module burst_counter (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clr,
   input  logic       inc,
   input  logic [3:0] last_idx,
   output logic [3:0] idx,
   output logic       last
);

   // Beat index: cleared while idle, advanced on each accepted beat.
   always_ff @(posedge CLK) begin
      if (RST)
         idx <= 4'd0;
      else if (clr)
         idx <= 4'd0;
      else if (inc)
         idx <= idx + 4'd1;
   end

   assign last = (idx == last_idx);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache fill path and the dcache fill/write-back path onto one
// word-wide memory port and sequences each line as a burst of single-word beats.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ownership on contention instead
// of fixed data-cache priority.
module cache_mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int unsigned IC_WORDS = 8,
   parameter int unsigned DC_WORDS = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ic_req,
   input  logic [31:0] ic_addr,
   output logic [31:0] ic_rdata,
   output logic        ic_rvalid,
   output logic [3:0]  ic_idx,
   output logic        ic_done,
   input  logic        dc_req,
   input  logic        dc_we,
   input  logic [31:0] dc_addr,
   input  logic [31:0] dc_wdata,
   output logic [31:0] dc_rdata,
   output logic        dc_rvalid,
   output logic [3:0]  dc_idx,
   output logic        dc_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [31:0] IC_MASK = line_mask(IC_WORDS);
   localparam logic [31:0] DC_MASK = line_mask(DC_WORDS);
   localparam logic [3:0]  IC_LAST = 4'(IC_WORDS - 1);
   localparam logic [3:0]  DC_LAST = 4'(DC_WORDS - 1);

   arb_state_t  state;
   logic [31:0] base;
   logic [3:0]  idx;
   logic [3:0]  last_idx;
   logic        last;
   logic        active;
   logic        ic_own;
   logic        dc_own;
   logic        beat_ack;
   logic        burst_done;
   logic        dc_wins;

   assign active     = (state != IDLE);
   assign ic_own     = (state == IC_FILL);
   assign dc_own     = (state == DC_FILL) || (state == DC_WB);
   assign beat_ack   = active & mem_ack;
   assign burst_done = beat_ack & last;
   assign last_idx   = ic_own ? IC_LAST : DC_LAST;

   burst_counter u_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (~active),
      .inc      (beat_ack),
      .last_idx (last_idx),
      .idx      (idx),
      .last     (last)
   );

`ifdef ARB_ROUND_ROBIN_EN
   requester_t last_owner;

   // Remember who was served last so a tie goes to the other requester.
   always_ff @(posedge CLK) begin
      if (RST)
         last_owner <= REQ_DC;
      else if (ic_done)
         last_owner <= REQ_IC;
      else if (dc_done)
         last_owner <= REQ_DC;
   end

   assign dc_wins = dc_req & (~ic_req | (last_owner == REQ_IC));
`else
   assign dc_wins = dc_req;
`endif

   // Arbitration and burst sequencing; the line base is latched at grant.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         base  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (dc_wins) begin
                  base  <= dc_addr & DC_MASK;
                  state <= dc_we ? DC_WB : DC_FILL;
               end else if (ic_req) begin
                  base  <= ic_addr & IC_MASK;
                  state <= IC_FILL;
               end
            end
            default: begin
               if (burst_done)
                  state <= IDLE;
            end
         endcase
      end
   end

   // Memory side: beat address stays inside the line since idx never exceeds WORDS-1.
   assign mem_req   = active;
   assign mem_we    = (state == DC_WB);
   assign mem_addr  = active ? (base | (32'(idx) << 2)) : 32'd0;
   assign mem_wdata = active ? dc_wdata : 32'd0;

   // Requester side: read data and completion are returned in the ack cycle.
   assign ic_rvalid = ic_own & mem_ack;
   assign ic_rdata  = ic_rvalid ? mem_rdata : 32'd0;
   assign ic_idx    = ic_own ? idx : 4'd0;
   assign ic_done   = ic_own & burst_done;

   assign dc_rvalid = (state == DC_FILL) & mem_ack;
   assign dc_rdata  = dc_rvalid ? mem_rdata : 32'd0;
   assign dc_idx    = dc_own ? idx : 4'd0;
   assign dc_done   = dc_own & burst_done;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one word-wide backing-memory port between the instruction-cache line-fill path and the data-cache fill/write-back path of the five-stage core. The block arbitrates between the two cache FSMs, latches the line address, and sequences a burst of single-word memory transactions. It returns read words (or fetches write-back words) beat by beat and signals completion to the winning requester. It sits between the two cache controllers and the unified memory.

## Interface
- `IC_WORDS`, 8: words per instruction-cache line; must be a power of 2, range 2..16.
- `DC_WORDS`, 4: words per data-cache line; must be a power of 2, range 2..16.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `ic_req` in 1: icache fill request; held high until `ic_done`.
- `ic_addr` in 32: icache miss address; low log2(IC_WORDS)+2 bits are ignored.
- `ic_rdata` out 32: fill word.
- `ic_rvalid` out 1: `ic_rdata` is valid this cycle.
- `ic_idx` out 4: line word index of the current beat.
- `ic_done` out 1: final beat of the burst.
- `dc_req` in 1: dcache request; held high until `dc_done`.
- `dc_we` in 1: 1 = write-back burst, 0 = fill burst; sampled at grant.
- `dc_addr` in 32: line address; low log2(DC_WORDS)+2 bits are ignored.
- `dc_wdata` in 32: write-back word for the beat selected by `dc_idx`.
- `dc_rdata` out 32: fill word.
- `dc_rvalid` out 1: `dc_rdata` is valid this cycle.
- `dc_idx` out 4: line word index of the current beat.
- `dc_done` out 1: final beat of the burst.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: beat is a write.
- `mem_addr` out 32: byte address, word-aligned.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid when `mem_ack` is high.
- `mem_ack` in 1: beat accepted or completed; one cycle per beat.

## Operation
- States: `IDLE`, `IC_FILL`, `DC_FILL`, `DC_WB`. A 4-bit beat counter `idx` runs alongside.
- `IDLE` arbitration uses the requests registered in the current cycle:
  - The winner's line base is latched: address with the low bits cleared.
  - `dc_we` is latched for a data-cache grant.
  - `idx` is cleared to 0.
  - State moves to the matching burst state.
- Only one requester is pending: that requester wins.
- Both requesters pending, default build: the data cache wins.
- In a burst state:
  - `mem_req` = 1.
  - `mem_addr` = base | (`idx` << 2). The OR is a concatenation with no carry, so the address never leaves the line.
  - `mem_we` = 1 only in `DC_WB`.
  - `mem_wdata` = `dc_wdata`, passed through combinationally.
- On `mem_ack`:
  - Read burst: the owner's `*_rvalid` = 1 and `*_rdata` = `mem_rdata`, both combinational from the ack.
  - `idx` increments.
- On `mem_ack` with `idx` = WORDS−1:
  - The owner's `*_done` = 1 in that same cycle.
  - State returns to `IDLE` at the next edge.
- Requesters must deassert `*_req` at the edge following `*_done`. Consequently `IDLE` never sees a stale request.
- A request seen in a burst state is held pending. No preemption.
- `*_idx` outputs carry `idx` while that requester owns the port, and 0 otherwise.
- Reset values: state `IDLE`, `idx` 0, all `mem_*`, `*_rvalid`, `*_done` = 0, `*_rdata`/`mem_addr`/`mem_wdata` = 0 whenever not owner/active.
- `RST` asserted during a burst aborts it at that edge:
  - No `*_done` is issued.
  - The memory side sees `mem_req` low the following cycle.
  - Requesters are reset by the same `RST`.

## Timing
- Grant latency: a request registered high in `IDLE` produces `mem_req` on the next cycle.
- Minimum burst length: WORDS+1 cycles from the request cycle, given `mem_ack` returned in the same cycle as `mem_req`.
- `mem_ack` may stall arbitrarily. `mem_addr`, `mem_we` and `mem_wdata` are stable until acked.
- `mem_ack` outside a burst state is ignored.
- Back-to-back bursts: at least one `IDLE` cycle lies between bursts, namely the cycle after `*_done`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-owner register, reset to "data", so the first contention goes to the icache.
  - It updates on each `*_done`.
  - When both requests are pending, the requester that was not last served wins.
  - Sole-request behaviour is unchanged.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority to the data cache. The register is not present.

## Structure
- Package `otter_mem_pkg` holds:
  - `arb_state_t` enum.
  - `requester_t` enum (`REQ_IC`, `REQ_DC`).
  - `MEM_WORD_BYTES` = 4.
- Sub-module `burst_counter`: clear/increment, `last` flag compare against a runtime length. Instantiated once, with length chosen by the current owner.

## Test plan
- Isolated icache fill:
  - Stimulus: `ic_addr`=0x0000_1234, `mem_ack` every cycle.
  - Response: `mem_addr` 0x1220, 0x1224 … 0x123C. Eight `ic_rvalid` pulses with idx 0..7. `ic_done` on the 8th beat. `mem_we`=0.
- Data-cache write-back:
  - Stimulus: `dc_we`=1, `dc_addr`=0x8000_004C, `mem_ack` every second cycle.
  - Response: 4 writes to 0x8000_0040..0x8000_004C with `mem_wdata` following `dc_idx`. `dc_rvalid` never asserted. `dc_done` on the 4th ack.
- Simultaneous requests, default build:
  - Stimulus: `ic_req` and `dc_req` rise in the same cycle.
  - Response: DC burst first, then one `IDLE` cycle, then the IC burst.
  - With `ARB_ROUND_ROBIN_EN`: IC burst first, then DC. A repeated tie then goes to IC again, because DC was last served.
- Stalled memory:
  - Stimulus: `mem_ack` held low for 5 cycles mid-burst.
  - Response: `mem_addr` and `idx` frozen for those cycles. No rvalid during the stall.
- Reset mid-burst:
  - Stimulus: `RST` at beat 3 of an IC fill.
  - Response: next cycle state `IDLE`, `mem_req`=0, no `ic_done`. A new `dc_req` is then granted normally starting at idx 0.
